// File: rtl/bscan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bscan_pkg
// Description : Shared constants, TAP-signal bundle and DR-operation decode
//               for the boundary-scan byte port.
// Revision    : 1.0  initial release
// ============================================================================
package bscan_pkg;

    localparam int BYTE_WIDTH           = 8;
    localparam int DEFAULT_RESULT_WIDTH = 16;
    localparam int DR_OP_W              = 3;

    typedef struct packed {
        logic test_logic_reset;
        logic ir_is_user;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
    } tap_sig_t;

    typedef enum logic [DR_OP_W-1:0] {
        DR_IDLE    = 3'd0,
        DR_RESET   = 3'd1,
        DR_CAPTURE = 3'd2,
        DR_SHIFT   = 3'd3,
        DR_UPDATE  = 3'd4
    } dr_op_e;

    function automatic logic tap_active(input tap_sig_t tap);
        return tap.ir_is_user && !tap.test_logic_reset;
    endfunction

    // TAP reset dominates; capture beats shift beats update if a host ever overlaps them.
    function automatic dr_op_e decode_dr_op(input tap_sig_t tap);
        dr_op_e op;
        op = DR_IDLE;
        if (tap.test_logic_reset) begin
            op = DR_RESET;
        end else if (tap_active(tap)) begin
            if (tap.capture_dr) begin
                op = DR_CAPTURE;
            end else if (tap.shift_dr) begin
                op = DR_SHIFT;
            end else if (tap.update_dr) begin
                op = DR_UPDATE;
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bscan_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bscan_byte_fifo
// Description : Synchronous received-byte FIFO on tck; a pop in the same
//               cycle as a push into a full FIFO frees the slot for it.
// Revision    : 1.0  initial release
// ============================================================================
module bscan_byte_fifo
    import bscan_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = BYTE_WIDTH
) (
    input  logic             tck,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bscan_byte_port.sv
`default_nettype none
// ============================================================================
// Module      : bscan_byte_port
// Description : User DR behind a BSCAN primitive: 8-bit scans deliver a byte
//               on a valid/ready stream, wider scans read back result_data.
//               Define BSCAN_BYTE_FIFO_EN for a FIFO_DEPTH-entry receive FIFO;
//               otherwise a single holding register buffers one byte.
// Revision    : 1.0  initial release
// ============================================================================
module bscan_byte_port
    import bscan_pkg::*;
#(
    parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    tdi,
    input  logic                    test_logic_reset,
    input  logic                    run_test_idle,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    output logic                    tdo,
    output logic [BYTE_WIDTH-1:0]   rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    input  logic [RESULT_WIDTH-1:0] result_data,
    input  logic                    result_valid,
    output logic                    rx_overflow
);

    localparam int                CNT_W      = $clog2(RESULT_WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = CNT_W'(RESULT_WIDTH);
    localparam logic [CNT_W-1:0]  C_CNT_BYTE = CNT_W'(BYTE_WIDTH);

    logic [RESULT_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    overflow_q, overflow_d;

    tap_sig_t                w_tap;
    dr_op_e                  w_dr_op;
    logic                    w_push;
    logic [BYTE_WIDTH-1:0]   w_push_byte;
    logic                    w_pop;
    logic                    w_buf_valid;
    logic                    w_buf_full;
    logic [BYTE_WIDTH-1:0]   w_buf_data;
    logic                    w_unused_rti;

    assign w_unused_rti = run_test_idle;

    assign w_tap = '{
        test_logic_reset: test_logic_reset,
        ir_is_user:       ir_is_user,
        capture_dr:       capture_dr,
        shift_dr:         shift_dr,
        update_dr:        update_dr
    };
    assign w_dr_op = decode_dr_op(w_tap);

    // After exactly eight shifts the scanned byte sits in the top bits, LSB lowest.
    assign w_push_byte = sr_q[RESULT_WIDTH-1 -: BYTE_WIDTH];

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        w_push = 1'b0;
        case (w_dr_op)
            DR_RESET: begin
                sr_d  = '0;
                cnt_d = '0;
            end
            DR_CAPTURE: begin
                sr_d  = result_valid ? result_data : '0;
                cnt_d = '0;
            end
            DR_SHIFT: begin
                sr_d = {tdi, sr_q[RESULT_WIDTH-1:1]};
                if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DR_UPDATE: begin
                w_push = (cnt_q == C_CNT_BYTE);
            end
            default: begin
            end
        endcase
    end

    assign w_pop      = w_buf_valid && rx_ready;
    assign overflow_d = overflow_q | (w_push && w_buf_full && !w_pop);

`ifdef BSCAN_BYTE_FIFO_EN
    logic w_fifo_empty;

    bscan_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_WIDTH)
    ) u_rx_fifo (
        .tck       (tck),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_byte),
        .pop       (w_pop),
        .pop_data  (w_buf_data),
        .full      (w_buf_full),
        .empty     (w_fifo_empty)
    );

    assign w_buf_valid = !w_fifo_empty;
`else
    localparam int C_UNUSED_FIFO_DEPTH = FIFO_DEPTH;

    logic                  hold_valid_q, hold_valid_d;
    logic [BYTE_WIDTH-1:0] hold_data_q, hold_data_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (w_pop) begin
            hold_valid_d = 1'b0;
        end
        if (w_push && (!hold_valid_q || w_pop)) begin
            hold_valid_d = 1'b1;
            hold_data_d  = w_push_byte;
        end
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign w_buf_valid = hold_valid_q;
    assign w_buf_full  = hold_valid_q;
    assign w_buf_data  = hold_data_q;
`endif

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign tdo         = sr_q[0];
    assign rx_valid    = w_buf_valid;
    assign rx_data     = w_buf_valid ? w_buf_data : '0;
    assign rx_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bscan_byte_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_bscan_byte_port
// Description : Directed and randomized scans against a bit-queue / byte-queue
//               reference model of the byte port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bscan_byte_port;

    localparam int RW    = 16;
    localparam int DEPTH = 4;
`ifdef BSCAN_BYTE_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic          tck = 1'b0;
    logic          rst_n = 1'b0;
    logic          tdi = 1'b0;
    logic          test_logic_reset = 1'b0;
    logic          run_test_idle = 1'b0;
    logic          ir_is_user = 1'b0;
    logic          capture_dr = 1'b0;
    logic          shift_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          rx_ready = 1'b0;
    logic          result_valid = 1'b0;
    logic [RW-1:0] result_data = '0;
    logic          tdo;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_ready = 1'b0;

    // Reference model: DR contents as a bit queue (index 0 = next bit out),
    // shifts since capture, delivered-byte queue and sticky overflow.
    bit         m_bits[$];
    int         m_count;
    logic [7:0] m_q[$];
    bit         m_ovf;

    bscan_byte_port #(
        .RESULT_WIDTH (RW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .tck              (tck),
        .rst_n            (rst_n),
        .tdi              (tdi),
        .test_logic_reset (test_logic_reset),
        .run_test_idle    (run_test_idle),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .tdo              (tdo),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .result_data      (result_data),
        .result_valid     (result_valid),
        .rx_overflow      (rx_overflow)
    );

    always #5 tck = ~tck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_dr();
        m_bits.delete();
        for (int i = 0; i < RW; i++) m_bits.push_back(1'b0);
        m_count = 0;
    endtask

    task automatic model_edge();
        bit         pop;
        logic [7:0] b;
        if (!rst_n) begin
            model_clear_dr();
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        pop = (m_q.size() > 0) && rx_ready;
        if (pop) void'(m_q.pop_front());
        if (test_logic_reset) begin
            model_clear_dr();
        end else if (ir_is_user) begin
            if (capture_dr) begin
                for (int i = 0; i < RW; i++) m_bits[i] = result_valid ? result_data[i] : 1'b0;
                m_count = 0;
            end else if (shift_dr) begin
                void'(m_bits.pop_front());
                m_bits.push_back(tdi);
                m_count++;
            end else if (update_dr && m_count == 8) begin
                for (int i = 0; i < 8; i++) b[i] = m_bits[RW-8+i];
                if (m_q.size() < CAP) m_q.push_back(b);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        check_val("rx_valid", rx_valid, (m_q.size() > 0));
        if (m_q.size() > 0) check_val("rx_data", rx_data, m_q[0]);
        check_val("tdo", tdo, m_bits[0]);
        check_val("rx_overflow", rx_overflow, m_ovf);
        model_edge();
        @(posedge tck);
        #1;
    endtask

    task automatic drive(input logic c, input logic s, input logic u, input logic d);
        capture_dr    = c;
        shift_dr      = s;
        update_dr     = u;
        tdi           = d;
        run_test_idle = 1'($urandom_range(0, 1));
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        cycle();
    endtask

    task automatic scan(input int n, input logic [31:0] v, input bit do_update,
                        output logic [31:0] seen);
        seen = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i < 32) seen[i] = tdo;
            drive(1'b0, 1'b1, 1'b0, (i < 32) ? v[i] : 1'($urandom_range(0, 1)));
        end
        if (do_update) drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] seen;
        int          n;
        int          r;

        model_clear_dr();
        m_q.delete();
        m_ovf = 1'b0;

        rst_n = 1'b0;
        @(posedge tck);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_rx_valid", rx_valid, 1'b0);
        check_val("rst_rx_data", rx_data, 8'h00);
        check_val("rst_overflow", rx_overflow, 1'b0);
        check_val("rst_tdo", tdo, 1'b0);
        rst_n = 1'b1;
        rx_ready = 1'b1;

        // Non-user IR: scan is ignored entirely.
        ir_is_user = 1'b0;
        scan(8, 32'h55, 1'b1, seen);
        check_val("inactive_tdo", seen[7:0], 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("inactive_no_push", rx_valid, 1'b0);

        // Seven shifts is not a byte.
        ir_is_user = 1'b1;
        scan(7, 32'h7F, 1'b1, seen);
        check_val("short_no_push", rx_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        scan(8, 32'h41, 1'b1, seen);
        check_val("byte41_valid", rx_valid, 1'b1);
        check_val("byte41_data", rx_data, 8'h41);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("byte41_single", rx_valid, 1'b0);

        result_valid = 1'b1;
        result_data  = 16'h1234;
        scan(16, 32'h0, 1'b1, seen);
        check_val("readback_tdo", seen[15:0], 16'h1234);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("readback_no_push", rx_valid, 1'b0);
        result_valid = 1'b0;

        // Zero byte is delivered like any other.
        scan(8, 32'h00, 1'b1, seen);
        check_val("byte00_valid", rx_valid, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-pressure: five bytes into a CAP-entry buffer.
        rx_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            scan(8, 32'(b), 1'b1, seen);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("bp_overflow", rx_overflow, 1'b1);
        check_val("bp_head", rx_data, 8'h01);
        rx_ready = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            check_val("bp_drain_valid", rx_valid, 1'b1);
            check_val("bp_drain_data", rx_data, 8'(k + 1));
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_val("bp_drained", rx_valid, 1'b0);
        check_val("bp_overflow_sticky", rx_overflow, 1'b1);

        // TAP reset keeps overflow.
        test_logic_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        test_logic_reset = 1'b0;
        check_val("tlr_keeps_overflow", rx_overflow, 1'b1);

        // Reset mid-scan discards the partial byte.
        scan(4, 32'hF, 1'b0, seen);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_val("midrst_overflow", rx_overflow, 1'b0);
        scan(8, 32'h0A, 1'b1, seen);
        check_val("midrst_valid", rx_valid, 1'b1);
        check_val("midrst_data", rx_data, 8'h0A);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("midrst_single", rx_valid, 1'b0);

        // Randomized scans with random back-pressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 150; t++) begin
            ir_is_user   = ($urandom_range(0, 7) != 0);
            result_valid = 1'($urandom_range(0, 1));
            result_data  = RW'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6) n = 8;
            else if (r < 8) n = 16;
            else n = $urandom_range(0, 20);
            scan(n, $urandom, ($urandom_range(0, 5) != 0), seen);
            if ($urandom_range(0, 15) == 0) begin
                test_logic_reset = 1'b1;
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                test_logic_reset = 1'b0;
            end
            r = $urandom_range(0, 2);
            for (int k = 0; k < r; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        end

        rand_ready = 1'b0;
        rx_ready   = 1'b1;
        for (int k = 0; k < CAP + 2; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("final_drained", rx_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bscan_byte_port.md
BSCAN_BYTE_PORT -- requirements
Module: bscan_byte_port

Interface
REQ-001 Parameter: RESULT_WIDTH, default 16, width of the readback result and of the DR shift register.
REQ-002 Parameter: FIFO_DEPTH, default 4, power of two >= 2, received-byte buffer depth (used only with BSCAN_BYTE_FIFO_EN).
REQ-003 tck  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 tdi, test_logic_reset, run_test_idle, ir_is_user, capture_dr, shift_dr, update_dr  in  1 each  BSCAN TAP-state signals, same meaning as on user_logic.
REQ-006 tdo  out  1  serial readback data, equal to shift-register bit 0.
REQ-007 rx_data / rx_valid / rx_ready  out 8 / out 1 / in 1  received byte stream; a transfer occurs on a cycle with rx_valid && rx_ready.
REQ-008 result_data / result_valid  in RESULT_WIDTH / in 1  readback value and its qualifier.
REQ-009 rx_overflow  out  1  sticky flag: a byte was dropped because the buffer was full.

Function
REQ-010 Active means ir_is_user=1 and test_logic_reset=0; when not active, capture_dr, shift_dr and update_dr SHALL be ignored.
REQ-011 Capture_dr (active): shift register <= result_valid ? result_data : 0; bit counter <= 0.
REQ-012 Shift_dr (active): shift register shifts right, tdi enters bit RESULT_WIDTH-1, old bit 0 is discarded; bit counter increments and saturates at RESULT_WIDTH.
REQ-013 tdo SHALL equal shift-register bit 0 combinationally, so the host samples LSB first.
REQ-014 Update_dr (active) with bit counter == 8: byte = shift register [RESULT_WIDTH-1:RESULT_WIDTH-8], pushed into the buffer.
REQ-015 Update_dr with bit counter != 8 (readback scan, aborted scan) SHALL push nothing.
REQ-016 Pushed byte SHALL present on rx_data with rx_valid=1 on the cycle after update_dr is sampled (1-cycle latency when the buffer is empty).
REQ-017 rx_data SHALL hold stable while rx_valid=1 && rx_ready=0; bytes leave in arrival order.
REQ-018 Push into a full buffer: byte dropped, rx_overflow <= 1; a simultaneous pop frees a slot, so the push then succeeds with no overflow.
REQ-019 Byte value 0x00 SHALL be delivered like any other byte; no in-band filtering.
REQ-020 Test_logic_reset=1: bit counter <= 0 and shift register <= 0; buffer contents and rx_overflow SHALL be kept.
REQ-021 Shift_dr sequences longer than RESULT_WIDTH SHALL keep shifting; the counter stays saturated and update pushes nothing.

Reset
REQ-022 rst_n=0 at a rising edge: shift register 0, bit counter 0, buffer empty, rx_valid 0, rx_data 0, rx_overflow 0, tdo 0.
REQ-023 Reset mid-scan SHALL discard the partial byte; the next capture_dr starts cleanly.
REQ-024 rx_overflow SHALL clear only on rst_n.

Configuration
REQ-025 Macro BSCAN_BYTE_FIFO_EN defined: the buffer is a FIFO_DEPTH-entry FIFO.
REQ-026 Macro BSCAN_BYTE_FIFO_EN undefined: the buffer is a single holding register; full whenever rx_valid=1; REQ-018 applies with depth 1.

Structure
REQ-027 Package bscan_pkg SHALL hold BYTE_WIDTH=8, the default RESULT_WIDTH=16 and the tap_active helper function/typedef.
REQ-028 Sub-module bscan_byte_fifo (synchronous FIFO, tck/rst_n, push/pop/full/empty) SHALL be instantiated only under BSCAN_BYTE_FIFO_EN.
REQ-029 Shift register, bit counter and update decode SHALL stay in bscan_byte_port.

Verification
REQ-030 Scan byte 0x41 LSB first (8 shifts), rx_ready=1 -> rx_valid for 1 cycle, rx_data=0x41, 1 cycle after update_dr.
REQ-031 result_valid=1, result_data=0x1234, 16-shift scan with tdi=0 -> tdo bits read 0x1234 LSB first; no rx_valid.
REQ-032 rx_ready=0, scan 5 bytes 0x01..0x05 with FIFO_EN and depth 4 -> 0x01..0x04 held, rx_overflow=1; release -> 0x01..0x04 in order.
REQ-033 Same stimulus without FIFO_EN -> only 0x01 delivered, rx_overflow=1.
REQ-034 ir_is_user=0 during byte scan 0x55 -> no rx_valid, tdo stays 0; 7-shift scan then update -> no push.
REQ-035 rst_n=0 after 4 shifts of a byte, then a full scan of 0x0A -> rx_data=0x0A only, rx_overflow=0.
